serial_word_deserializer: RTL

Receive end of the single-bit serial link that accompanies our bit-level combinational blocks. It accepts one bit per valid/ready beat (LSB first), reassembles WIDTH-bit words, closes short words on a frame marker, and delivers words through a 2-entry output buffer with a valid/ready handshake. It sits between a bit-serial source (pad sampler or upstream serializer) and word-wide consumer logic inside `top`-level integrations.

---
 rtl/serial_word_deserializer_if.sv | 42 ++++
 rtl/serial_word_deserializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_word_deserializer_if.sv
// Bundles the serial input beat channel and the word output channel of
// serial_word_deserializer. The master side drives bits and takes words;
// the slave side is the deserializer itself.
interface serial_word_deserializer_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             in_bit;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_perr;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_bit,
    output in_valid,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_count,
    input  out_perr,
    input  out_valid
  );

  modport slave (
    input  in_bit,
    input  in_valid,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_count,
    output out_perr,
    output out_valid
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// Serial-to-word deserializer: collects LSB-first bits into WIDTH-bit words,
// closes short words on in_last, and delivers them through a 2-entry FIFO.
// Optional even-parity beat after each word: SERIAL_WORD_DESERIALIZER_PARITY_EN.
module serial_word_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  serial_word_deserializer_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] count;
    logic             perr;
  } word_t;

  logic             run_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  word_t            mem_q [2];
  word_t            head;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q;

  logic             accept;
  logic             pop;
  logic             push;
  word_t            push_word;

  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] new_word;
  logic [CNT_W-1:0] new_count;
  logic             close_word;

  // Ready depends only on registered state: out of reset and FIFO not full.
  assign bus.in_ready  = run_q && (occ_q != 2'd2);
  assign bus.out_valid = (occ_q != 2'd0);

  assign head          = mem_q[rd_ptr_q];
  assign bus.out_data  = head.data;
  assign bus.out_count = head.count;
  assign bus.out_perr  = head.perr;

  assign accept     = bus.in_valid && bus.in_ready;
  assign pop        = bus.out_valid && bus.out_ready;

  // Word as it would look with the current bit merged in at position bcnt.
  assign bit_mask   = WIDTH'(1) << bcnt_q;
  assign new_word   = bus.in_bit ? (sr_q | bit_mask) : sr_q;
  assign new_count  = bcnt_q + CNT_W'(1);
  assign close_word = (bcnt_q == CNT_W'(WIDTH - 1)) || bus.in_last;

`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q;
  logic [CNT_W-1:0] hold_count_q;
  logic             hold_load;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a closed word waits for its parity beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && close_word) state_d = PARITY;
      PARITY:  if (accept)               state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Datapath controls: collect bits, park the closed word, push on parity.
  always_comb begin
    sr_d      = sr_q;
    bcnt_d    = bcnt_q;
    push      = 1'b0;
    push_word = '0;
    hold_load = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (close_word) begin
            sr_d      = '0;
            bcnt_d    = '0;
            hold_load = 1'b1;
          end else begin
            sr_d      = new_word;
            bcnt_d    = new_count;
          end
        end
      end
      PARITY: begin
        if (accept) begin
          push            = 1'b1;
          push_word.data  = hold_data_q;
          push_word.count = hold_count_q;
          push_word.perr  = (^hold_data_q) ^ bus.in_bit;
        end
      end
      default: ;
    endcase
  end

  // Closed word held here while its parity beat is awaited.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q  <= '0;
      hold_count_q <= '0;
    end else if (hold_load) begin
      hold_data_q  <= new_word;
      hold_count_q <= new_count;
    end
  end
`else
  // Datapath controls: collect bits and push each word as it closes.
  always_comb begin
    sr_d      = sr_q;
    bcnt_d    = bcnt_q;
    push      = 1'b0;
    push_word = '0;
    if (accept) begin
      if (close_word) begin
        sr_d            = '0;
        bcnt_d          = '0;
        push            = 1'b1;
        push_word.data  = new_word;
        push_word.count = new_count;
        push_word.perr  = 1'b0;
      end else begin
        sr_d   = new_word;
        bcnt_d = new_count;
      end
    end
  end
`endif

  // Shift register, bit counter and the post-reset run flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      bcnt_q <= '0;
      run_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bcnt_q <= bcnt_d;
      run_q  <= 1'b1;
    end
  end

  // Two-entry output FIFO; simultaneous push and pop keeps occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end
endmodule
